// File: rtl/wasm_instr_loader.sv
// Instruction-memory loader: packs a host byte stream little-endian into 64-bit
// words and drives the core's instruction-memory write interface from address 0.
module wasm_instr_loader #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LEN_W  = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_rdy,
  input  logic              i_instr_mem_wr_rdy,
  output logic              o_instr_mem_wr_vld,
  output logic [ADDR_W-1:0] o_instr_mem_wr_addr,
  output logic [63:0]       o_instr_mem_wr_data,
  output logic              o_instr_mem_wr_finish,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // Compare width wide enough to hold both i_len and the largest legal length.
  localparam int unsigned CmpW = (LEN_W > ADDR_W + 4) ? LEN_W : ADDR_W + 4;
  localparam logic [CmpW-1:0] MaxLen = CmpW'(1) << (ADDR_W + 3);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StFinish} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2:0]         lane_q, lane_d;
  logic [63:0]        pack_q, pack_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               byte_rdy;

  logic [CmpW-1:0]    len_ext;
  logic               len_illegal;
  logic               len_zero;

  assign len_ext     = CmpW'(i_len);
  assign len_illegal = len_ext > MaxLen;
  assign len_zero    = (i_len == '0);

  // Next-state logic: start decode, byte packing and the write handshake.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    rem_d    = rem_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = err_q;
    byte_rdy = 1'b0;

    unique case (state_q)
      // Starts are only honoured when not busy; FINISH accepts them like IDLE.
      StIdle, StFinish: begin
        if (i_start) begin
          if (len_illegal) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            err_d  = 1'b0;
            addr_d = '0;
            lane_d = '0;
            pack_d = '0;
            last_d = 1'b0;
            if (len_zero) begin
              state_d = StFinish;
              done_d  = 1'b1;
            end else begin
              rem_d   = i_len;
              state_d = StCollect;
            end
          end
        end
      end

      StCollect: begin
        byte_rdy = 1'b1;
        if (i_byte_vld) begin
          pack_d[{lane_q, 3'b000} +: 8] = i_byte_data;
          lane_d = lane_q + 3'd1;
          rem_d  = rem_q - LEN_W'(1);
          if (lane_q == 3'd7 || rem_q == LEN_W'(1)) begin
            state_d = StWrite;
            last_d  = (rem_q == LEN_W'(1));
          end
        end
      end

      StWrite: begin
        if (i_instr_mem_wr_rdy) begin
          addr_d = addr_q + ADDR_W'(1);
          if (last_q) begin
            state_d = StFinish;
            done_d  = 1'b1;
          end else begin
            state_d = StCollect;
            lane_d  = '0;
            pack_d  = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset also aborts a load in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    o_byte_rdy            = byte_rdy;
    o_instr_mem_wr_vld    = (state_q == StWrite);
    o_instr_mem_wr_addr   = addr_q;
    o_instr_mem_wr_data   = pack_q;
    o_instr_mem_wr_finish = (state_q == StFinish);
    o_busy                = (state_q == StCollect) || (state_q == StWrite);
    o_done                = done_q;
    o_err                 = err_q;
  end

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Bench for wasm_instr_loader: random byte streams and write back-pressure, with a
// queue scoreboard fed from a byte-level model and a negedge monitor.
module tb_wasm_instr_loader;
  // LEN_W widened by one bit so a length just past the legal maximum is expressible.
  localparam int unsigned AW = 15;
  localparam int unsigned LW = 19;
  localparam int unsigned MaxLen = 8 * (1 << AW);

  logic          clk = 1'b0;
  logic          i_rst, i_start, i_byte_vld, wr_rdy;
  logic [LW-1:0] i_len;
  logic [7:0]    i_byte_data;
  logic          o_byte_rdy, wr_vld, wr_finish, o_busy, o_done, o_err;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;

  always #5 clk = ~clk;

  wasm_instr_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .i_clk                 (clk),
    .i_rst                 (i_rst),
    .i_start               (i_start),
    .i_len                 (i_len),
    .i_byte_vld            (i_byte_vld),
    .i_byte_data           (i_byte_data),
    .o_byte_rdy            (o_byte_rdy),
    .i_instr_mem_wr_rdy    (wr_rdy),
    .o_instr_mem_wr_vld    (wr_vld),
    .o_instr_mem_wr_addr   (wr_addr),
    .o_instr_mem_wr_data   (wr_data),
    .o_instr_mem_wr_finish (wr_finish),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_err                 (o_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] bytes[$];
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  bit         expect_fin = 0;
  bit         mon_en = 0;
  bit         rdy_low = 0;
  int         rdy_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_word(input int unsigned a, input logic [63:0] d);
    word_t w;
    w.addr = AW'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Reference: word k holds bytes 8k..8k+7, byte 8k+j at bits 8j, absent bytes zero.
  task automatic push_model();
    int n = bytes.size();
    for (int k = 0; k < (n + 7) / 8; k++) begin
      logic [63:0] d = '0;
      for (int j = 0; j < 8; j++)
        if (8 * k + j < n) d = d | (64'(bytes[8 * k + j]) << (8 * j));
      push_word(k, d);
    end
  endtask

  task automatic monitor();
    logic          hold = 1'b0;
    logic [AW-1:0] ha = '0;
    logic [63:0]   hd = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold = 1'b0;
        expect_fin = 0;
        continue;
      end
      if (o_done) done_cnt++;
      chk("byte_rdy_outside_collect", 64'(o_byte_rdy && (!o_busy || wr_vld)), 64'd0);
      if (hold) begin
        chk("stall_vld", 64'(wr_vld), 64'd1);
        chk("stall_addr", 64'(wr_addr), 64'(ha));
        chk("stall_data", wr_data, hd);
      end
      if (expect_fin) begin
        chk("finish_after_last", 64'(wr_finish), 64'd1);
        chk("done_after_last", 64'(o_done), 64'd1);
        expect_fin = 0;
      end
      if (wr_vld && wr_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          word_t w = exp_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(w.addr));
          chk("wr_data", wr_data, w.data);
          if (exp_q.size() == 0) expect_fin = 1;
        end
      end
      hold = wr_vld && !wr_rdy;
      ha   = wr_addr;
      hd   = wr_data;
    end
  endtask

  task automatic rdy_drv();
    forever begin
      @(posedge clk);
      #2;
      wr_rdy = !rdy_low && ($urandom_range(99) < rdy_pct);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_byte_rdy"}, 64'(o_byte_rdy), 64'd0);
    chk({tag, "_vld"}, 64'(wr_vld), 64'd0);
    chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_data"}, wr_data, 64'd0);
    chk({tag, "_finish"}, 64'(wr_finish), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_err"}, 64'(o_err), 64'd0);
  endtask

  task automatic start(input int unsigned len);
    i_byte_vld = 1'b0;
    i_start    = 1'b1;
    i_len      = LW'(len);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Present bytes[0..n-1] with random gaps; optionally pulse a stray start mid-load.
  task automatic drive(input int n, input int pct, input bit inject);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 5000) begin
      i_byte_vld  = ($urandom_range(99) < pct);
      i_byte_data = i_byte_vld ? bytes[idx] : 8'($urandom);
      i_start     = inject && (cyc == 3);
      i_len       = LW'(1);
      @(negedge clk);
      if (i_byte_vld && o_byte_rdy) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    i_start    = 1'b0;
    i_byte_vld = 1'b0;
    chk("bytes_accepted", 64'(idx), 64'(n));
  endtask

  task automatic wait_finish();
    int cyc = 0;
    while (!wr_finish && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("finish_reached", 64'(wr_finish), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    i_rst  = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    mon_en = 1;
  endtask

  task automatic fill_random(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask

  task automatic run_load(input int n, input int pct, input bit inject);
    push_model();
    done_cnt = 0;
    start(n);
    drive(n, pct, inject);
    wait_finish();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_byte_vld = 1'b0; i_byte_data = '0;
    wr_rdy = 1'b0;
    fork
      monitor();
      rdy_drv();
    join_none
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // T1: 16 sequential bytes, always ready.
    bytes.delete();
    for (int i = 0; i < 16; i++) bytes.push_back(8'(i));
    push_word(0, 64'h0706050403020100);
    push_word(1, 64'h0F0E0D0C0B0A0908);
    done_cnt = 0;
    start(16);
    drive(16, 100, 0);
    wait_finish();

    // T2: 11 bytes, zero-padded tail word.
    bytes.delete();
    for (int i = 0; i < 11; i++) bytes.push_back(8'(i));
    push_word(0, 64'h0706050403020100);
    push_word(1, 64'h00000000000A0908);
    done_cnt = 0;
    start(11);
    drive(11, 100, 0);
    wait_finish();

    // T3: write stalled 5 cycles while bytes are offered.
    bytes.delete();
    for (int i = 0; i < 8; i++) bytes.push_back(8'(8'h10 + i));
    push_word(0, 64'h1716151413121110);
    done_cnt = 0;
    rdy_low = 1;
    start(8);
    drive(8, 100, 0);
    i_byte_vld  = 1'b1;
    i_byte_data = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      chk("t3_vld", 64'(wr_vld), 64'd1);
      chk("t3_byte_rdy", 64'(o_byte_rdy), 64'd0);
      @(posedge clk);
      #1;
    end
    rdy_low = 0;
    wait_finish();
    i_byte_vld = 1'b0;

    // T4: 24 random bytes with gaps and back-pressure.
    rdy_pct = 60;
    fill_random(24);
    run_load(24, 50, 0);

    // T5: zero length, over-long length, max legal length, start while busy.
    rdy_pct = 100;
    done_cnt = 0;
    start(0);
    @(negedge clk);
    chk("t5_zero_finish", 64'(wr_finish), 64'd1);
    chk("t5_zero_done", 64'(o_done), 64'd1);
    chk("t5_zero_vld", 64'(wr_vld), 64'd0);
    @(posedge clk);
    #1;
    start(MaxLen + 1);
    @(negedge clk);
    chk("t5_ill_err", 64'(o_err), 64'd1);
    chk("t5_ill_busy", 64'(o_busy), 64'd0);
    chk("t5_ill_finish", 64'(wr_finish), 64'd0);
    chk("t5_ill_vld", 64'(wr_vld), 64'd0);
    @(posedge clk);
    #1;
    start(MaxLen);
    @(negedge clk);
    chk("t5_max_err_clear", 64'(o_err), 64'd0);
    chk("t5_max_busy", 64'(o_busy), 64'd1);
    @(posedge clk);
    #1;
    start(MaxLen + 1);
    @(negedge clk);
    chk("t5_busy_start_err", 64'(o_err), 64'd0);
    chk("t5_busy_start_busy", 64'(o_busy), 64'd1);
    @(posedge clk);
    #1;
    do_reset();

    // T6: abort after 5 bytes, then reloads must carry no stale lanes.
    fill_random(16);
    start(16);
    drive(5, 100, 0);
    do_reset();
    fill_random(3);
    run_load(3, 100, 0);
    fill_random(16);
    run_load(16, 100, 0);

    // Random loads, one with a stray start pulse mid-load.
    for (int t = 0; t < 6; t++) begin
      rdy_pct = $urandom_range(20, 100);
      fill_random($urandom_range(1, 40));
      run_load(bytes.size(), $urandom_range(30, 100), t == 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
